reg_bank_ctrl: RTL and testbench
================================

# reg_bank_ctrl

Access controller for the 16×8 register bank. It serializes requests from two requesters, A (execute/write-back) and B (load/debug), onto the bank's single read-or-write port using round-robin arbitration. Bank control signals come from registers so the level-sensitive bank sees stable address, data and mode for a whole cycle. Read data is captured and returned through a registered response pulse.

## Interface
- ADDR_W, default 4: register address width; the bank depth is 2^ADDR_W.
- DATA_W, default 8: register data width.
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req_valid / b_req_valid  in  1  request present.
- a_req_ready / b_req_ready  out  1  request accepted this cycle when valid && ready.
- a_req_we / b_req_we  in  1  1 = write, 0 = dual read.
- a_req_waddr / b_req_waddr  in  ADDR_W  write address.
- a_req_wdata / b_req_wdata  in  DATA_W  write data.
- a_req_raddr1, a_req_raddr2 / b_req_raddr1, b_req_raddr2  in  ADDR_W  read addresses.
- a_resp_valid / b_resp_valid  out  1  one-cycle completion pulse, for reads and writes.
- a_resp_data1, a_resp_data2 / b_resp_data1, b_resp_data2  out  DATA_W  read results. Valid with resp_valid. Value is 0 for writes.
- rb_w_r  out  1  bank mode (1 = write); drives bank w_r.
- rb_w_add, rb_r_add_1, rb_r_add_2  out  ADDR_W  bank addresses.
- rb_data  out  DATA_W  bank write data.
- rb_data_1, rb_data_2  in  DATA_W  bank read data (combinational from the bank).
- busy  out  1  high when the controller is not in IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS on accept.
  - ACCESS → RESP always.
  - RESP → IDLE always.
- Arbitration happens in IDLE only. Ready is combinational:
  - Only one valid: that requester is granted.
  - Both valid: the requester not recorded in last_grant is granted.
  - Never more than one ready at a time.
  - Both ready signals are 0 outside IDLE.
- On accept:
  - Latch we, addresses and wdata into the rb_* output registers.
  - Latch the grant id.
  - Update last_grant.
- ACCESS, write: rb_w_r = 1 for exactly this cycle, with rb_w_add and rb_data held.
- ACCESS, read: rb_w_r = 0 with rb_r_add_1 and rb_r_add_2 held. rb_data_1 and rb_data_2 are sampled at the end of the cycle into the response registers.
- RESP: resp_valid pulses for the granted requester only. The other requester's resp_valid stays 0.
- The resp_data registers hold their value until the next completion for that requester. A write completion loads 0.
- Outside a write ACCESS cycle, rb_w_r = 0 (bank in read mode). Addresses keep their last latched values.

## Timing
- Reset values:
  - State IDLE, last_grant = B, so A wins the first tie.
  - All rb_* outputs 0.
  - All ready, resp_valid and resp_data outputs 0.
  - busy = 0.
- Latency: with accept at edge N, ACCESS is the cycle N→N+1 and resp_valid is high in cycle N+1→N+2.
- Throughput: one operation per 3 cycles. The next accept is possible at edge N+3.
- rb_w_r is a register output and must be glitch-free. It is never high for more than one cycle per write.
- Requester inputs are don't-care after the accept cycle. Held-valid requesters keep valid high until they see ready.
- Write then read of the same address by any requester returns the new value, because operations are strictly serialized.
- Simultaneous valids on every IDLE cycle produce an alternating grant sequence A, B, A, B.
- Reset mid-operation:
  - rb_w_r drops to 0 asynchronously.
  - No resp_valid is issued.
  - An in-flight write is treated as not performed and must be reissued by the requester.

## Structure
- Shared package reg_bank_pkg:
  - ADDR_W and DATA_W defaults.
  - State encoding localparams ST_IDLE, ST_ACCESS, ST_RESP.
  - Requester id constants REQ_A, REQ_B.
- Sub-module rr_arb2: two-input round-robin arbiter.
  - Inputs: valids, last_grant, enable (= state IDLE).
  - Outputs: one-hot grant.
  - Purely combinational; last_grant is kept in the parent.
- Top-level instantiation connects rb_* directly to the existing reg_bank ports.

## Test plan
- Reset then A write addr 3 data 8'hA9 → a_req_ready = 1 in cycle 0; rb_w_r = 1 in exactly one cycle with rb_w_add = 3 and rb_data = 8'hA9; a_resp_valid pulses 2 cycles after accept; b_resp_valid stays 0.
- A read raddr1 = 3, raddr2 = 0 after that write → a_resp_data1 = 8'hA9 and a_resp_data2 = 8'h00, with a_resp_valid 2 cycles after accept.
- A and B valid together from reset, both holding valid → grants A, B, A, B on consecutive accepts, spaced 3 cycles apart; never both ready in the same cycle.
- B write addr 15 = 8'h5C, then A read raddr1 = 15 while B keeps requesting → A is granted next by round-robin and returns 8'h5C.
- rst_n asserted during the ACCESS of a write to addr 7 → rb_w_r is 0 immediately, busy = 0, and no resp_valid follows.
- Checker across all tests:
  - rb_w_r is high only in ACCESS of a write, at most 1 cycle.
  - Every accept yields exactly one resp_valid, to the requester that was granted.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants for the register-bank access controller.
package reg_bank_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Purely combinational; the parent keeps
// last_grant. On a tie the requester that did not win last time is granted.
module rr_arb2
    import reg_bank_pkg::*;
(
    input  logic [1:0] valid,       // bit 0 = A, bit 1 = B
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant        // one-hot, bit 0 = A, bit 1 = B
);

    // One-hot grant, forced to zero when the controller cannot accept.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid[0] && (!valid[1] || last_grant == REQ_B)) begin
                grant = 2'b01;
            end else if (valid[1]) begin
                grant = 2'b10;
            end
        end
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Serializes two requesters onto the single read-or-write port of the
// register bank. Each operation takes IDLE -> ACCESS -> RESP; bank controls
// are registered so the level-sensitive bank sees them stable for a cycle.
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_waddr,
    input  logic [DATA_W-1:0] a_req_wdata,
    input  logic [ADDR_W-1:0] a_req_raddr1,
    input  logic [ADDR_W-1:0] a_req_raddr2,
    output logic              a_resp_valid,
    output logic [DATA_W-1:0] a_resp_data1,
    output logic [DATA_W-1:0] a_resp_data2,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_waddr,
    input  logic [DATA_W-1:0] b_req_wdata,
    input  logic [ADDR_W-1:0] b_req_raddr1,
    input  logic [ADDR_W-1:0] b_req_raddr2,
    output logic              b_resp_valid,
    output logic [DATA_W-1:0] b_resp_data1,
    output logic [DATA_W-1:0] b_resp_data2,

    output logic              rb_w_r,
    output logic [ADDR_W-1:0] rb_w_add,
    output logic [ADDR_W-1:0] rb_r_add_1,
    output logic [ADDR_W-1:0] rb_r_add_2,
    output logic [DATA_W-1:0] rb_data,
    input  logic [DATA_W-1:0] rb_data_1,
    input  logic [DATA_W-1:0] rb_data_2,

    output logic              busy
);

    logic [1:0]        state;
    logic              last_grant;
    logic              grant_id;
    logic [1:0]        grant;
    logic              accept;
    logic              sel;
    logic              req_we;
    logic [ADDR_W-1:0] req_waddr;
    logic [DATA_W-1:0] req_wdata;
    logic [ADDR_W-1:0] req_raddr1;
    logic [ADDR_W-1:0] req_raddr2;

    rr_arb2 u_arb (
        .valid      ({b_req_valid, a_req_valid}),
        .last_grant (last_grant),
        .enable     (state == ST_IDLE),
        .grant      (grant)
    );

    assign a_req_ready = grant[0];
    assign b_req_ready = grant[1];
    assign accept      = |grant;
    assign sel         = grant[1] ? REQ_B : REQ_A;
    assign busy        = (state != ST_IDLE);

    // Select the granted requester's fields for latching into the bank port.
    always_comb begin
        req_we     = a_req_we;
        req_waddr  = a_req_waddr;
        req_wdata  = a_req_wdata;
        req_raddr1 = a_req_raddr1;
        req_raddr2 = a_req_raddr2;
        if (sel == REQ_B) begin
            req_we     = b_req_we;
            req_waddr  = b_req_waddr;
            req_wdata  = b_req_wdata;
            req_raddr1 = b_req_raddr1;
            req_raddr2 = b_req_raddr2;
        end
    end

    // Operation sequencer and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= REQ_B;
            grant_id   <= REQ_A;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_ACCESS;
                        last_grant <= sel;
                        grant_id   <= sel;
                    end
                end
                ST_ACCESS: state <= ST_RESP;
                ST_RESP:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Bank port registers; the write strobe is high only for the ACCESS
    // cycle of a write, addresses and data keep their last latched values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_w_r     <= 1'b0;
            rb_w_add   <= '0;
            rb_r_add_1 <= '0;
            rb_r_add_2 <= '0;
            rb_data    <= '0;
        end else begin
            rb_w_r <= 1'b0;
            if (accept) begin
                rb_w_r     <= req_we;
                rb_w_add   <= req_waddr;
                rb_r_add_1 <= req_raddr1;
                rb_r_add_2 <= req_raddr2;
                rb_data    <= req_wdata;
            end
        end
    end

    // Completion: capture bank read data (or 0 for a write) at the end of
    // ACCESS and pulse resp_valid for the granted requester during RESP.
    // rb_w_r is high during ACCESS exactly when the operation is a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_resp_valid <= 1'b0;
            b_resp_valid <= 1'b0;
            a_resp_data1 <= '0;
            a_resp_data2 <= '0;
            b_resp_data1 <= '0;
            b_resp_data2 <= '0;
        end else begin
            a_resp_valid <= 1'b0;
            b_resp_valid <= 1'b0;
            if (state == ST_ACCESS) begin
                if (grant_id == REQ_A) begin
                    a_resp_valid <= 1'b1;
                    a_resp_data1 <= rb_w_r ? '0 : rb_data_1;
                    a_resp_data2 <= rb_w_r ? '0 : rb_data_2;
                end else begin
                    b_resp_valid <= 1'b1;
                    b_resp_data1 <= rb_w_r ? '0 : rb_data_1;
                    b_resp_data2 <= rb_w_r ? '0 : rb_data_2;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Bench for reg_bank_ctrl: behavioural 16x8 bank, per-requester scoreboard
// queues filled at accept and drained at each response.
module tb_reg_bank_ctrl;

    logic       clk;
    logic       rst_n;
    logic       clr_bank;
    logic       a_req_valid, a_req_ready, a_req_we;
    logic [3:0] a_req_waddr, a_req_raddr1, a_req_raddr2;
    logic [7:0] a_req_wdata;
    logic       a_resp_valid;
    logic [7:0] a_resp_data1, a_resp_data2;
    logic       b_req_valid, b_req_ready, b_req_we;
    logic [3:0] b_req_waddr, b_req_raddr1, b_req_raddr2;
    logic [7:0] b_req_wdata;
    logic       b_resp_valid;
    logic [7:0] b_resp_data1, b_resp_data2;
    logic       rb_w_r;
    logic [3:0] rb_w_add, rb_r_add_1, rb_r_add_2;
    logic [7:0] rb_data, rb_data_1, rb_data_2;
    logic       busy;

    typedef struct {
        logic       we;
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic [3:0] r1;
        logic [3:0] r2;
    } req_t;

    req_t       qa[$];
    req_t       qb[$];
    req_t       acc;
    logic       acc_id;
    int         since_acc;
    int         gl_id[$];
    int         gl_cyc[$];
    int         cyc;
    int         checks;
    int         errors;
    int         wr_hi;
    int         a_resp_cnt;
    int         b_resp_cnt;
    logic [7:0] bank[16];
    logic [7:0] ref_mem[16];

    reg_bank_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_waddr(a_req_waddr), .a_req_wdata(a_req_wdata),
        .a_req_raddr1(a_req_raddr1), .a_req_raddr2(a_req_raddr2),
        .a_resp_valid(a_resp_valid), .a_resp_data1(a_resp_data1), .a_resp_data2(a_resp_data2),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_waddr(b_req_waddr), .b_req_wdata(b_req_wdata),
        .b_req_raddr1(b_req_raddr1), .b_req_raddr2(b_req_raddr2),
        .b_resp_valid(b_resp_valid), .b_resp_data1(b_resp_data1), .b_resp_data2(b_resp_data2),
        .rb_w_r(rb_w_r), .rb_w_add(rb_w_add), .rb_r_add_1(rb_r_add_1), .rb_r_add_2(rb_r_add_2),
        .rb_data(rb_data), .rb_data_1(rb_data_1), .rb_data_2(rb_data_2),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural level-sensitive bank, written while rb_w_r is high at an edge.
    always @(posedge clk) begin
        if (clr_bank) begin
            for (int i = 0; i < 16; i++) bank[i] <= 8'h00;
        end else if (rb_w_r) begin
            bank[rb_w_add] <= rb_data;
        end
    end
    assign rb_data_1 = bank[rb_r_add_1];
    assign rb_data_2 = bank[rb_r_add_2];

    // Cycle monitor: protocol invariants, timing of strobes/responses, scoreboard.
    always @(negedge clk) begin : mon
        req_t       e;
        logic       id;
        logic [7:0] e1, e2, g1, g2;
        logic       exp_av, exp_bv;
        cyc++;
        if (!rst_n) begin
            since_acc = 99;
            qa.delete();
            qb.delete();
            if (clr_bank) for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        end else begin
            if (since_acc < 99) since_acc++;
            checks++;
            if (a_req_ready && b_req_ready) begin
                errors++; $display("FAIL both_ready: a=%b b=%b required not both at cyc %0d", a_req_ready, b_req_ready, cyc);
            end
            checks++;
            if (busy !== (since_acc == 1 || since_acc == 2)) begin
                errors++; $display("FAIL busy: got %b want %b at cyc %0d", busy, (since_acc == 1 || since_acc == 2), cyc);
            end
            checks++;
            if (rb_w_r !== (since_acc == 1 && acc.we)) begin
                errors++; $display("FAIL rb_w_r: got %b want %b at cyc %0d", rb_w_r, (since_acc == 1 && acc.we), cyc);
            end
            if (rb_w_r) wr_hi++;
            if (since_acc == 1) begin
                checks++;
                if (acc.we && (rb_w_add !== acc.waddr || rb_data !== acc.wdata)) begin
                    errors++; $display("FAIL bank_wr_port: got add %0d data %h want add %0d data %h", rb_w_add, rb_data, acc.waddr, acc.wdata);
                end else if (!acc.we && (rb_r_add_1 !== acc.r1 || rb_r_add_2 !== acc.r2)) begin
                    errors++; $display("FAIL bank_rd_port: got %0d/%0d want %0d/%0d", rb_r_add_1, rb_r_add_2, acc.r1, acc.r2);
                end
            end
            exp_av = (since_acc == 2) && (acc_id == 1'b0);
            exp_bv = (since_acc == 2) && (acc_id == 1'b1);
            checks++;
            if (a_resp_valid !== exp_av) begin
                errors++; $display("FAIL a_resp_valid: got %b want %b at cyc %0d", a_resp_valid, exp_av, cyc);
            end
            checks++;
            if (b_resp_valid !== exp_bv) begin
                errors++; $display("FAIL b_resp_valid: got %b want %b at cyc %0d", b_resp_valid, exp_bv, cyc);
            end
            if (a_resp_valid) a_resp_cnt++;
            if (b_resp_valid) b_resp_cnt++;
            if (a_resp_valid || b_resp_valid) begin
                id = b_resp_valid;
                checks++;
                if ((id && qb.size() == 0) || (!id && qa.size() == 0)) begin
                    errors++; $display("FAIL resp_unexpected: requester %0d responded with empty queue", id);
                end else begin
                    if (id) e = qb.pop_front();
                    else    e = qa.pop_front();
                    if (e.we) begin
                        e1 = 8'h00; e2 = 8'h00;
                        ref_mem[e.waddr] = e.wdata;
                    end else begin
                        e1 = ref_mem[e.r1]; e2 = ref_mem[e.r2];
                    end
                    g1 = id ? b_resp_data1 : a_resp_data1;
                    g2 = id ? b_resp_data2 : a_resp_data2;
                    if (g1 !== e1 || g2 !== e2) begin
                        errors++; $display("FAIL resp_data: req %0d got %h/%h want %h/%h", id, g1, g2, e1, e2);
                    end
                end
            end
            if (a_req_valid && a_req_ready) begin
                e.we = a_req_we; e.waddr = a_req_waddr; e.wdata = a_req_wdata;
                e.r1 = a_req_raddr1; e.r2 = a_req_raddr2;
                qa.push_back(e); acc = e; acc_id = 1'b0; since_acc = 0;
                gl_id.push_back(0); gl_cyc.push_back(cyc);
            end else if (b_req_valid && b_req_ready) begin
                e.we = b_req_we; e.waddr = b_req_waddr; e.wdata = b_req_wdata;
                e.r1 = b_req_raddr1; e.r2 = b_req_raddr2;
                qb.push_back(e); acc = e; acc_id = 1'b1; since_acc = 0;
                gl_id.push_back(1); gl_cyc.push_back(cyc);
            end
        end
    end

    task automatic set_req(input bit id, input bit we, input logic [3:0] wa, input logic [7:0] wd,
                           input logic [3:0] r1, input logic [3:0] r2);
        if (!id) begin
            a_req_we = we; a_req_waddr = wa; a_req_wdata = wd;
            a_req_raddr1 = r1; a_req_raddr2 = r2; a_req_valid = 1'b1;
        end else begin
            b_req_we = we; b_req_waddr = wa; b_req_wdata = wd;
            b_req_raddr1 = r1; b_req_raddr2 = r2; b_req_valid = 1'b1;
        end
    endtask

    task automatic do_reset(input bit clr);
        rst_n = 1'b0;
        clr_bank = clr;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        clr_bank = 1'b0;
    endtask

    // Issue one request, wait for accept (bounded) and for its completion.
    task automatic issue(input bit id, input bit we, input logic [3:0] wa, input logic [7:0] wd,
                         input logic [3:0] r1, input logic [3:0] r2, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        @(posedge clk); #1;
        set_req(id, we, wa, wd, r1, r2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((!id && a_req_ready) || (id && b_req_ready)) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        @(posedge clk); #1;
        if (!id) a_req_valid = 1'b0; else b_req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL accept_timeout: requester %0d not ready within 20 cycles", id);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (gl_id.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        do_reset(1'b1);
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rb_w_r !== 1'b0 || a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy %b w_r %b ready %b%b want 0000", busy, rb_w_r, a_req_ready, b_req_ready);
        end
        checks++;
        if (rb_w_add !== 4'd0 || rb_r_add_1 !== 4'd0 || rb_r_add_2 !== 4'd0 || rb_data !== 8'h00) begin
            errors++; $display("FAIL reset_rb: %0d %0d %0d %h want all 0", rb_w_add, rb_r_add_1, rb_r_add_2, rb_data);
        end
        checks++;
        if (a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0 || a_resp_data1 !== 8'h00 ||
            a_resp_data2 !== 8'h00 || b_resp_data1 !== 8'h00 || b_resp_data2 !== 8'h00) begin
            errors++; $display("FAIL reset_resp: valid %b%b data %h %h %h %h want all 0", a_resp_valid, b_resp_valid,
                               a_resp_data1, a_resp_data2, b_resp_data1, b_resp_data2);
        end
    endtask

    task automatic test_write;
        int w0, ra0, rb0, waited;
        w0 = wr_hi; ra0 = a_resp_cnt; rb0 = b_resp_cnt;
        issue(1'b0, 1'b1, 4'd3, 8'hA9, 4'd0, 4'd0, waited);
        checks++;
        if (waited !== 0) begin
            errors++; $display("FAIL write_ready_cycle0: waited %0d want 0", waited);
        end
        checks++;
        if (wr_hi - w0 !== 1) begin
            errors++; $display("FAIL write_strobe_cycles: got %0d want 1", wr_hi - w0);
        end
        checks++;
        if (a_resp_cnt - ra0 !== 1 || b_resp_cnt - rb0 !== 0) begin
            errors++; $display("FAIL write_resp_count: a %0d b %0d want 1 0", a_resp_cnt - ra0, b_resp_cnt - rb0);
        end
        checks++;
        if (a_resp_data1 !== 8'h00 || a_resp_data2 !== 8'h00) begin
            errors++; $display("FAIL write_resp_data: got %h/%h want 00/00", a_resp_data1, a_resp_data2);
        end
    endtask

    task automatic test_read_after_write;
        int ra0, waited;
        ra0 = a_resp_cnt;
        issue(1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 4'd0, waited);
        checks++;
        if (a_resp_data1 !== 8'hA9 || a_resp_data2 !== 8'h00) begin
            errors++; $display("FAIL raw_data: got %h/%h want a9/00", a_resp_data1, a_resp_data2);
        end
        checks++;
        if (a_resp_cnt - ra0 !== 1) begin
            errors++; $display("FAIL raw_resp_count: got %0d want 1", a_resp_cnt - ra0);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        bit ok;
        do_reset(1'b1);
        base = gl_id.size();
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 4'd1, 8'h11, 4'd0, 4'd0);
        set_req(1'b1, 1'b1, 4'd2, 8'h22, 4'd0, 4'd0);
        wait_log(base + 4, ok);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_timeout: %0d accepts want 4", gl_id.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (gl_id[base+k] !== (k % 2)) begin
                    errors++; $display("FAIL b2b_grant_%0d: got %0d want %0d", k, gl_id[base+k], k % 2);
                end
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (gl_cyc[base+k] - gl_cyc[base+k-1] !== 3) begin
                    errors++; $display("FAIL b2b_spacing_%0d: got %0d want 3", k, gl_cyc[base+k] - gl_cyc[base+k-1]);
                end
            end
        end
        repeat (3) @(negedge clk); #1;
    endtask

    task automatic test_rr_priority;
        int base;
        bit ok1, ok2, ok3;
        base = gl_id.size();
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 4'd15, 8'h5C, 4'd0, 4'd0);
        wait_log(base + 1, ok1);
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 4'd0, 8'h00, 4'd15, 4'd3);
        set_req(1'b0, 1'b0, 4'd0, 8'h00, 4'd15, 4'd1);
        wait_log(base + 2, ok2);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        wait_log(base + 3, ok3);
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        repeat (3) @(negedge clk); #1;
        checks++;
        if (!(ok1 && ok2 && ok3)) begin
            errors++; $display("FAIL rr_timeout: %0d accepts want 3", gl_id.size() - base);
        end else if (gl_id[base] !== 1 || gl_id[base+1] !== 0 || gl_id[base+2] !== 1) begin
            errors++; $display("FAIL rr_order: got %0d%0d%0d want 101", gl_id[base], gl_id[base+1], gl_id[base+2]);
        end
        checks++;
        if (a_resp_data1 !== 8'h5C || a_resp_data2 !== 8'h11) begin
            errors++; $display("FAIL rr_a_data: got %h/%h want 5c/11", a_resp_data1, a_resp_data2);
        end
        checks++;
        if (b_resp_data1 !== 8'h5C || b_resp_data2 !== 8'h00) begin
            errors++; $display("FAIL rr_b_data: got %h/%h want 5c/00", b_resp_data1, b_resp_data2);
        end
    endtask

    task automatic test_reset_mid_access;
        int ra0, rb0, waited;
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 4'd7, 8'h77, 4'd0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        #1;
        checks++;
        if (!ok || rb_w_r !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre: accepted %b w_r %b busy %b want 1 1 1", ok, rb_w_r, busy);
        end
        ra0 = a_resp_cnt; rb0 = b_resp_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rb_w_r !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_async: w_r %b busy %b want 0 0", rb_w_r, busy);
        end
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk); #1;
        checks++;
        if (a_resp_cnt != ra0 || b_resp_cnt != rb0) begin
            errors++; $display("FAIL abort_no_resp: a %0d b %0d extra responses want 0 0", a_resp_cnt - ra0, b_resp_cnt - rb0);
        end
        issue(1'b0, 1'b0, 4'd0, 8'h00, 4'd7, 4'd15, waited);
        checks++;
        if (a_resp_data1 !== 8'h00 || a_resp_data2 !== 8'h5C) begin
            errors++; $display("FAIL abort_not_written: got %h/%h want 00/5c", a_resp_data1, a_resp_data2);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; wr_hi = 0; a_resp_cnt = 0; b_resp_cnt = 0; since_acc = 99;
        acc.we = 1'b0; acc.waddr = 4'd0; acc.wdata = 8'h00; acc.r1 = 4'd0; acc.r2 = 4'd0; acc_id = 1'b0;
        rst_n = 1'b0; clr_bank = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_waddr = 4'd0; a_req_wdata = 8'h00;
        a_req_raddr1 = 4'd0; a_req_raddr2 = 4'd0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_waddr = 4'd0; b_req_wdata = 8'h00;
        b_req_raddr1 = 4'd0; b_req_raddr2 = 4'd0;
        test_reset();
        test_write();
        test_read_after_write();
        test_back_to_back();
        test_rr_priority();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
